move_input: RTL and testbench

Front-end for the 2048 capstone. It turns four raw push-buttons into the one-hot `direction` code that the game logic consumes. It synchronizes and debounces each button, then accepts one move per press. A legal press produces exactly one single-cycle `direction` pulse; at all other times `direction` is 4'b0000.

---
 rtl/game_pkg.sv | 21 ++
 rtl/move_input_if.sv | 19 +
 rtl/debouncer.sv | 40 ++++
 rtl/move_input.sv | 138 +++++++++++++
 tb/tb_move_input.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared 2048 move encoding and the move-input FSM state type.
// Direction codes are one-hot; the bit index matches the button order {left, up, down, right}.
package game_pkg;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } move_fsm_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/move_input_if.sv
// Raw push-button inputs and the one-hot move pulse of the move_input front-end.
// master drives the buttons and observes direction; slave is the move_input side.
interface move_input_if;
    logic       btn_right;
    logic       btn_left;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] direction;

    modport master (
        output btn_right, btn_left, btn_up, btn_down,
        input  direction
    );

    modport slave (
        input  btn_right, btn_left, btn_up, btn_down,
        output direction
    );
endinterface

// File: rtl/debouncer.sv
// One button: 2-flop synchronizer then a stability counter; stable follows din after
// DEBOUNCE_CYCLES consecutive differing synced cycles (latency DEBOUNCE_CYCLES+2), no backpressure.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
            // Any agreement restarts the count, so only an unbroken run can flip stable.
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_input.sv
// Four buttons -> debounced press events -> one single-cycle one-hot direction pulse per press.
// Latency DEBOUNCE_CYCLES+3 from raw edge, no backpressure; `MOVE_INPUT_REPEAT_EN adds hold auto-repeat.
module move_input
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic         clk,
    input  logic         rst,
    move_input_if.slave  io
);

    logic [3:0] raw;
    logic [3:0] stable;
    logic [3:0] stable_q;
    logic [3:0] press;
    logic [3:0] fire_sel;
    logic [3:0] dir_nxt;
    logic       rpt_fire;
    move_fsm_t  state;
    move_fsm_t  state_nxt;

    assign raw = {io.btn_left, io.btn_up, io.btn_down, io.btn_right};

    for (genvar i = 0; i < 4; i++) begin : g_db
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk    (clk),
            .rst    (rst),
            .din    (raw[i]),
            .stable (stable[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 4'b0000;
        end else begin
            stable_q <= stable;
        end
    end

    assign press = stable & ~stable_q;

`ifdef MOVE_INPUT_REPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_ok;
    logic          rpt_first;
    logic [3:0]    fire_code;

    // rpt_cnt counts edges since the last pulse, FIRE cycles included, so the period keeps its phase.
    assign rpt_fire = (state == HOLD) && rpt_ok && (stable == fire_code) &&
                      (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_ok    <= 1'b0;
            rpt_first <= 1'b0;
            fire_code <= DIR_NONE;
        end else if (state == IDLE) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
            rpt_ok    <= (state_nxt == FIRE);
            if (state_nxt == FIRE) begin
                fire_code <= press;
            end
        end else begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else if (rpt_ok) begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
            if ((stable & ~fire_code) != 4'b0000) begin
                rpt_ok <= 1'b0;
            end
        end
    end

    assign fire_sel = (state == HOLD) ? fire_code : press;
`else
    assign rpt_fire = 1'b0;
    assign fire_sel = press;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                // A chord goes straight to HOLD so none of its buttons can fire later.
                if (press != 4'b0000) begin
                    state_nxt = is_onehot(press) ? FIRE : HOLD;
                end
            end
            FIRE: state_nxt = HOLD;
            HOLD: begin
                if (stable == 4'b0000) begin
                    state_nxt = IDLE;
                end else if (rpt_fire) begin
                    state_nxt = FIRE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dir_nxt = DIR_NONE;
        if (state_nxt == FIRE) begin
            dir_nxt = fire_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io.direction <= DIR_NONE;
        end else begin
            io.direction <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_move_input.sv
// Scoreboard bench for move_input with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Expected pulses (cycle, code) are queued as buttons are driven and matched as direction rises.
module tb_move_input;
    import game_pkg::*;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    typedef struct {
        int         cyc;
        logic [3:0] dir;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;
    exp_t sb[$];

    move_input_if bif ();

    move_input #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [3:0] code);
        exp_t e;
        e.cyc = at;
        e.dir = code;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bif.direction != DIR_NONE) begin
                if (sb.size() == 0) begin
                    check("spurious_pulse", int'(bif.direction), int'(DIR_NONE));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_code", int'(bif.direction), int'(e.dir));
                    check("pulse_cycle", cyc, e.cyc);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("missing_pulse", int'(bif.direction), int'(e.dir));
            end
        end
    end

    initial begin
        int p;
        checks        = 0;
        errors        = 0;
        mon_en        = 1'b0;
        rst           = 1'b1;
        bif.btn_right = 1'b0;
        bif.btn_left  = 1'b0;
        bif.btn_up    = 1'b0;
        bif.btn_down  = 1'b0;

        // Reset state
        wait_cyc(3);
        check("reset_dir", int'(bif.direction), int'(DIR_NONE));
        rst    = 1'b0;
        mon_en = 1'b1;
        wait_cyc(2);

        // Clean up press held 20 cycles
        bif.btn_up = 1'b1;
        expect_pulse(cyc + LAT, DIR_UP);
        wait_cyc(20);
        bif.btn_up = 1'b0;
        wait_cyc(12);
        check("quiet_after_up", int'(bif.direction), int'(DIR_NONE));

        // Left glitches shorter than the debounce window
        for (int len = 1; len <= 3; len++) begin
            bif.btn_left = 1'b1;
            wait_cyc(len);
            bif.btn_left = 1'b0;
            wait_cyc(10);
        end
        check("quiet_after_glitch", int'(bif.direction), int'(DIR_NONE));

        // Right+down chord rejected, then a lone down press fires
        bif.btn_right = 1'b1;
        bif.btn_down  = 1'b1;
        wait_cyc(20);
        bif.btn_right = 1'b0;
        bif.btn_down  = 1'b0;
        wait_cyc(12);
        bif.btn_down = 1'b1;
        expect_pulse(cyc + LAT, DIR_DOWN);
        wait_cyc(20);
        bif.btn_down = 1'b0;
        wait_cyc(12);

        // Left fires; up pressed during the hold never fires, even after left lets go
        bif.btn_left = 1'b1;
        expect_pulse(cyc + LAT, DIR_LEFT);
        wait_cyc(10);
        bif.btn_up = 1'b1;
        wait_cyc(10);
        bif.btn_left = 1'b0;
        wait_cyc(15);
        check("quiet_second_button", int'(bif.direction), int'(DIR_NONE));
        bif.btn_up = 1'b0;
        wait_cyc(12);
        bif.btn_up = 1'b1;
        expect_pulse(cyc + LAT, DIR_UP);
        wait_cyc(15);
        bif.btn_up = 1'b0;
        wait_cyc(12);

        // Reset asserted on the FIRE cycle with right still held
        bif.btn_right = 1'b1;
        p = cyc;
        expect_pulse(p + LAT, DIR_RIGHT);
        wait_cyc(LAT);
        rst = 1'b1;
        wait_cyc(1);
        check("reset_in_fire", int'(bif.direction), int'(DIR_NONE));
        rst = 1'b0;
        expect_pulse(cyc + LAT, DIR_RIGHT);
        wait_cyc(20);
        bif.btn_right = 1'b0;
        wait_cyc(12);

`ifdef MOVE_INPUT_REPEAT_EN
        // Auto-repeat: fire, +20, then every 8 until the release reaches stable
        bif.btn_down = 1'b1;
        p = cyc;
        expect_pulse(p + LAT, DIR_DOWN);
        for (int t = p + LAT + 20; t <= p + 60 + DEB + 2; t += 8) begin
            expect_pulse(t, DIR_DOWN);
        end
        wait_cyc(60);
        bif.btn_down = 1'b0;
        wait_cyc(15);
`endif

        wait_cyc(20);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
